// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and controller states.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate, purely combinational, zero latency.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = en_i ? ({WIDTH{1'b0}} - a_i) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO; done pulses WIDTH+2 cycles after start.
// start and MTHI/MTLO writes are accepted only while idle; anything arriving while busy is dropped.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               div_q, div_d, dz_q, dz_d;
  logic               done_q, done_d;

  logic               signed_op, div_op;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     msum, rsh, rsub;
  logic               rge;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign div_op    = (op == MD_DIVU) || (op == MD_DIV);

  md_negate #(.WIDTH(WIDTH)) u_abs_a (.en_i(signed_op & A[WIDTH-1]), .a_i(A), .y_o(a_abs));
  md_negate #(.WIDTH(WIDTH)) u_abs_b (.en_i(signed_op & B[WIDTH-1]), .a_i(B), .y_o(b_abs));
  md_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.en_i(sa_q ^ sb_q), .a_i(acc_q), .y_o(prod_fix));
  // A zero divisor keeps the all-ones quotient regardless of operand signs.
  md_negate #(.WIDTH(WIDTH)) u_neg_quo (.en_i((sa_q ^ sb_q) & ~dz_q),
                                        .a_i(acc_q[WIDTH-1:0]), .y_o(quo_fix));
  md_negate #(.WIDTH(WIDTH)) u_neg_rem (.en_i(sa_q), .a_i(acc_q[2*WIDTH-1:WIDTH]), .y_o(rem_fix));

  // Multiply step: add multiplicand into the upper half, then shift the whole pair right.
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // Divide step: shift next dividend bit into the partial remainder and try a subtract.
  assign rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rge  = rsh >= {1'b0, opnd_q};
  assign rsub = rsh - {1'b0, opnd_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    div_d  = div_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          div_d  = div_op;
          sa_d   = signed_op & A[WIDTH-1];
          sb_d   = signed_op & B[WIDTH-1];
          dz_d   = div_op && (B == '0);
          cnt_d  = '0;
          acc_d  = {{WIDTH{1'b0}}, (div_op ? a_abs : b_abs)};
          opnd_d = div_op ? b_abs : a_abs;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = div_q ? {(rge ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], rge}
                      : {msum, acc_q[WIDTH-1:1]};
      end
      FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: each task drives one scenario and checks hand-computed results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge: presents start for one edge, then waits (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_multu_max();
    int lat, bc;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL hi_hold: got %h want fffffffe", hi); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo: got %h want fffffff1", lo); end
    @(negedge clk);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
  endtask

  task automatic test_div_corners();
    int lat, bc;
    @(negedge clk);
    run_op(2'b10, 32'd100, 32'd0, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu_zero_hi: got %h want 00000064", hi); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_zero_latency: got %0d want 34", lat); end
    @(negedge clk);
    run_op(2'b11, 32'hFFFF_FF9C, 32'd0, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FF9C) begin errors++; $display("FAIL div_zero_hi: got %h want ffffff9c", hi); end
    @(negedge clk);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_ignore_while_busy();
    int lat;
    @(negedge clk);
    op = 2'b10; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b00; A = 32'd2; B = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mthi_while_busy: got %h want 00000000", hi); end
    lat = 6;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency: got %0d want 34", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ignore_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ignore_hi: got %h want 00000002", hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    int lat, bc;
    bit seen;
    @(negedge clk);
    op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stray_done: got %b want 0", seen); end
    run_op(2'b00, 32'd6, 32'd7, lat, bc);
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL after_reset_lo: got %h want 0000002a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL after_reset_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hABCD;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo: got %h want 0000abcd", lo); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtxx_done: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd4, lat, bc);
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL b2b_first_lo: got %h want 0000000c", lo); end
    run_op(2'b10, 32'd50, 32'd8, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h want 00000006", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h want 00000002", hi); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corners();
    test_ignore_while_busy();
    test_reset_midop();
    test_mthi_mtlo();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
